wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file; drives its rd / rd_din / reg_write write port.
- Merges two producers onto the single write port:
  - in-order pipeline results (ALU, load, PC+4);
  - out-of-order results from a long-latency unit (mul/div) over a valid/ready handshake.
- Performs load-data extraction and extension, buffers one long-latency result, and guarantees that result forward progress with a starvation counter.

Parameters:
- XLEN, 32, datapath width.
- STARVE_LIMIT, 4, consecutive cycles a buffered ML result may lose arbitration before the pipeline is back-pressured (1..15).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_wb_valid  input  1  pipeline result valid.
- o_wb_ready  output  1  pipeline result accepted this cycle when high with i_wb_valid.
- i_wb_rd  input  5  pipeline destination register.
- i_wb_sel  input  2  result select: 0 ALU, 1 LOAD, 2 PC+4, 3 reserved (treated as ALU).
- i_wb_alu_result  input  XLEN  ALU result.
- i_wb_pc_plus4  input  XLEN  link value.
- i_wb_load_word  input  XLEN  raw aligned memory word.
- i_wb_funct3  input  3  load type.
- i_wb_addr_lsb  input  2  load byte offset.
- i_ml_valid  input  1  long-latency result valid.
- o_ml_ready  output  1  long-latency result accepted when high with i_ml_valid.
- i_ml_rd  input  5  long-latency destination.
- i_ml_data  input  XLEN  long-latency result.
- o_rd  output  5  register-file write address.
- o_rd_din  output  XLEN  register-file write data.
- o_reg_write  output  1  register-file write enable.
- o_buf_valid  output  1  ML buffer occupied (hazard visibility).
- o_buf_rd  output  5  rd held in ML buffer.

Behaviour:
- **Reset** (async, i_rst_n low): o_reg_write=0, o_rd=0, o_rd_din=0, buffer empty, starve_cnt=0. Consequently o_buf_valid=0, o_buf_rd=0, o_ml_ready=1, o_wb_ready=1.
- **Output timing:** o_rd / o_rd_din / o_reg_write are registered. A write selected in cycle N appears on the outputs in cycle N+1 for exactly one cycle.
- **Ready signals:**
  - o_ml_ready = !buf_valid (combinational).
  - o_wb_ready = !(buf_valid && starve_cnt == STARVE_LIMIT) (combinational).
- **Pipeline data mux:**
  - sel 0/3: alu_result.
  - sel 2: pc_plus4.
  - sel 1, by funct3:
    - 000 LB: byte at addr_lsb, sign-extended.
    - 001 LH: halfword at addr_lsb[1], sign-extended.
    - 010 LW: full word.
    - 100 LBU: byte, zero-extended.
    - 101 LHU: halfword, zero-extended.
    - others: raw word.
  - addr_lsb[0] is ignored for LH/LHU.
- **Arbitration per cycle, in priority order:**
  1. buf_valid && starve_cnt == STARVE_LIMIT: write buffer, clear buffer, starve_cnt=0. Pipeline is not accepted.
  2. i_wb_valid (o_wb_ready high): write pipeline result. If buf_valid, starve_cnt++.
  3. buf_valid: write buffer, clear buffer, starve_cnt=0.
  4. i_ml_valid (buffer empty): write i_ml_data directly. The buffer is bypassed.
- **Buffer capture:** i_ml_valid && o_ml_ready while the port is taken by case 2 loads the buffer with {i_ml_rd, i_ml_data}. starve_cnt starts at 0 and counts from the next losing cycle.
- **Buffer occupancy:** the buffer holds at most one entry. A producer whose handshake is not accepted must hold its values stable until it is.
- **x0 writes:** any winner with rd==0 is consumed normally, but o_reg_write=0 (o_rd/o_rd_din still update).
- **Idle:** no candidate → o_reg_write=0 next cycle; o_rd / o_rd_din hold their previous values.
- **Counter:** starve_cnt is $clog2(STARVE_LIMIT+1) bits and saturates at STARVE_LIMIT.
- **Mid-operation reset:** a buffered ML result is discarded; the ML unit must re-issue.

Test Plan:
1. **Reset then ALU write:** reset, then i_wb_valid=1, sel=0, rd=5, alu=0x1234_5678 → next cycle o_reg_write=1, o_rd=5, o_rd_din=0x12345678; following cycle o_reg_write=0.
2. **Load extraction:** load_word=0x80FF_7F01.
   - LB lsb=3 → 0xFFFF_FF80.
   - LBU lsb=1 → 0x0000_007F.
   - LH lsb=2 → 0xFFFF_80FF.
   - LHU lsb=0 → 0x0000_7F01.
   - LW → 0x80FF_7F01.
3. **Collision:**
   - Stimulus: pipeline rd=3 and ML rd=7 (data 0xAA) both valid in cycle N; pipeline idle in N+1.
   - Cycle N: ML accepted into buffer (o_ml_ready high in N); o_buf_valid=1, o_buf_rd=7 from N+1.
   - N+1 outputs: rd=3 written; o_ml_ready=0 during N+1.
   - N+2 outputs: rd=7 / 0xAA written.
4. **Starvation (STARVE_LIMIT=4):**
   - Stimulus: buffer loaded, pipeline valid every cycle.
   - Required: 4 pipeline writes, then o_wb_ready=0 for one cycle.
   - Buffered result written in that cycle; o_wb_ready returns to 1 the next cycle, and the held pipeline entry is written then.
5. **x0 suppression:** pipeline rd=0, alu=0xDEAD → o_reg_write stays 0, o_wb_ready=1, the entry is consumed, and no stall occurs.
6. **Async reset with buffer full:** assert i_rst_n=0 mid-cycle → o_buf_valid, o_reg_write and o_rd_din drop immediately. After release, o_ml_ready=1 and there is no stale write of the buffered entry.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges in-order pipeline results and buffered long-latency
// results onto the single register-file write port, with a starvation guard.
module wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wb_valid,
    output logic            o_wb_ready,
    input  logic [4:0]      i_wb_rd,
    input  logic [1:0]      i_wb_sel,
    input  logic [XLEN-1:0] i_wb_alu_result,
    input  logic [XLEN-1:0] i_wb_pc_plus4,
    input  logic [XLEN-1:0] i_wb_load_word,
    input  logic [2:0]      i_wb_funct3,
    input  logic [1:0]      i_wb_addr_lsb,
    input  logic            i_ml_valid,
    output logic            o_ml_ready,
    input  logic [4:0]      i_ml_rd,
    input  logic [XLEN-1:0] i_ml_data,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_rd_din,
    output logic            o_reg_write,
    output logic            o_buf_valid,
    output logic [4:0]      o_buf_rd
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    function automatic logic [XLEN-1:0] load_extract(
        input logic [XLEN-1:0] word,
        input logic [2:0]      funct3,
        input logic [1:0]      lsb
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lsb)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lsb[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  load_extract = {{(XLEN-8){b[7]}}, b};
            3'b001:  load_extract = {{(XLEN-16){h[15]}}, h};
            3'b100:  load_extract = {{(XLEN-8){1'b0}}, b};
            3'b101:  load_extract = {{(XLEN-16){1'b0}}, h};
            default: load_extract = word;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        sat_inc = (cnt == LIMIT) ? cnt : cnt + 1'b1;
    endfunction

    logic            buf_valid_q, buf_valid_d;
    logic [4:0]      buf_rd_q, buf_rd_d;
    logic [XLEN-1:0] buf_data_q, buf_data_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rd_din_q, rd_din_d;
    logic            reg_write_q, reg_write_d;

    logic            force_buf;
    logic [XLEN-1:0] pipe_data;

    assign force_buf  = buf_valid_q && (starve_cnt_q == LIMIT);
    assign o_wb_ready = !force_buf;
    assign o_ml_ready = !buf_valid_q;

    always_comb begin
        case (i_wb_sel)
            2'd1:    pipe_data = load_extract(i_wb_load_word, i_wb_funct3, i_wb_addr_lsb);
            2'd2:    pipe_data = i_wb_pc_plus4;
            default: pipe_data = i_wb_alu_result;
        endcase
    end

    always_comb begin
        buf_valid_d  = buf_valid_q;
        buf_rd_d     = buf_rd_q;
        buf_data_d   = buf_data_q;
        starve_cnt_d = starve_cnt_q;
        rd_d         = rd_q;
        rd_din_d     = rd_din_q;
        reg_write_d  = 1'b0;

        if (force_buf || (!i_wb_valid && buf_valid_q)) begin
            rd_d         = buf_rd_q;
            rd_din_d     = buf_data_q;
            reg_write_d  = (buf_rd_q != 5'd0);
            buf_valid_d  = 1'b0;
            buf_rd_d     = 5'd0;
            starve_cnt_d = '0;
        end else if (i_wb_valid) begin
            rd_d        = i_wb_rd;
            rd_din_d    = pipe_data;
            reg_write_d = (i_wb_rd != 5'd0);
            if (buf_valid_q) begin
                starve_cnt_d = sat_inc(starve_cnt_q);
            end else if (i_ml_valid) begin
                // Port is taken this cycle: park the ML result for a later slot.
                buf_valid_d  = 1'b1;
                buf_rd_d     = i_ml_rd;
                buf_data_d   = i_ml_data;
                starve_cnt_d = '0;
            end
        end else if (i_ml_valid) begin
            rd_d        = i_ml_rd;
            rd_din_d    = i_ml_data;
            reg_write_d = (i_ml_rd != 5'd0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_valid_q  <= 1'b0;
            buf_rd_q     <= 5'd0;
            buf_data_q   <= '0;
            starve_cnt_q <= '0;
            rd_q         <= 5'd0;
            rd_din_q     <= '0;
            reg_write_q  <= 1'b0;
        end else begin
            buf_valid_q  <= buf_valid_d;
            buf_rd_q     <= buf_rd_d;
            buf_data_q   <= buf_data_d;
            starve_cnt_q <= starve_cnt_d;
            rd_q         <= rd_d;
            rd_din_q     <= rd_din_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign o_rd        = rd_q;
    assign o_rd_din    = rd_din_q;
    assign o_reg_write = reg_write_q;
    assign o_buf_valid = buf_valid_q;
    assign o_buf_rd    = buf_rd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, load extraction, collision,
// starvation, x0 suppression and asynchronous reset with a full buffer.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_sel;
    logic [31:0] wb_alu;
    logic [31:0] wb_pc4;
    logic [31:0] wb_load;
    logic [2:0]  wb_f3;
    logic [1:0]  wb_lsb;
    logic        ml_valid;
    logic        ml_ready;
    logic [4:0]  ml_rd;
    logic [31:0] ml_data;
    logic [4:0]  rd;
    logic [31:0] rd_din;
    logic        reg_write;
    logic        buf_valid;
    logic [4:0]  buf_rd;

    int tests  = 0;
    int failed = 0;

    wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_wb_valid      (wb_valid),
        .o_wb_ready      (wb_ready),
        .i_wb_rd         (wb_rd),
        .i_wb_sel        (wb_sel),
        .i_wb_alu_result (wb_alu),
        .i_wb_pc_plus4   (wb_pc4),
        .i_wb_load_word  (wb_load),
        .i_wb_funct3     (wb_f3),
        .i_wb_addr_lsb   (wb_lsb),
        .i_ml_valid      (ml_valid),
        .o_ml_ready      (ml_ready),
        .i_ml_rd         (ml_rd),
        .i_ml_data       (ml_data),
        .o_rd            (rd),
        .o_rd_din        (rd_din),
        .o_reg_write     (reg_write),
        .o_buf_valid     (buf_valid),
        .o_buf_rd        (buf_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ld_lsb [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                                32'h0000_7F01, 32'h80FF_7F01};

    initial begin
        rst_n    = 1'b0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_sel = 2'd0; wb_alu = 32'h0;
        wb_pc4   = 32'h0; wb_load = 32'h0; wb_f3 = 3'b0; wb_lsb = 2'd0;
        ml_valid = 1'b0; ml_rd = 5'd0; ml_data = 32'h0;
        tick(); tick();

        chk("rst_reg_write", {31'b0, reg_write}, 32'd0);
        chk("rst_rd",        {27'b0, rd}, 32'd0);
        chk("rst_rd_din",    rd_din, 32'd0);
        chk("rst_buf_valid", {31'b0, buf_valid}, 32'd0);
        chk("rst_buf_rd",    {27'b0, buf_rd}, 32'd0);
        chk("rst_ml_ready",  {31'b0, ml_ready}, 32'd1);
        chk("rst_wb_ready",  {31'b0, wb_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // ALU write, then idle hold
        wb_valid = 1'b1; wb_sel = 2'd0; wb_rd = 5'd5; wb_alu = 32'h1234_5678;
        tick();
        chk("alu_we",  {31'b0, reg_write}, 32'd1);
        chk("alu_rd",  {27'b0, rd}, 32'd5);
        chk("alu_din", rd_din, 32'h1234_5678);
        wb_valid = 1'b0;
        tick();
        chk("idle_we",  {31'b0, reg_write}, 32'd0);
        chk("idle_rd",  {27'b0, rd}, 32'd5);
        chk("idle_din", rd_din, 32'h1234_5678);

        // Load extraction
        wb_load = 32'h80FF_7F01; wb_sel = 2'd1; wb_rd = 5'd9; wb_alu = 32'h0;
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1'b1; wb_f3 = ld_f3[i]; wb_lsb = ld_lsb[i];
            tick();
            chk($sformatf("load%0d_din", i), rd_din, ld_exp[i]);
        end
        wb_sel = 2'd2; wb_pc4 = 32'h0000_1004;
        tick();
        chk("pc4_din", rd_din, 32'h0000_1004);
        wb_sel = 2'd3; wb_alu = 32'hCAFE_0003;
        tick();
        chk("sel3_din", rd_din, 32'hCAFE_0003);
        wb_valid = 1'b0; wb_sel = 2'd0;
        tick();

        // Collision
        wb_valid = 1'b1; wb_rd = 5'd3; wb_alu = 32'h33;
        ml_valid = 1'b1; ml_rd = 5'd7; ml_data = 32'hAA;
        chk("col_ml_ready_n", {31'b0, ml_ready}, 32'd1);
        tick();
        ml_valid = 1'b0; wb_valid = 1'b0;
        chk("col_n1_rd",     {27'b0, rd}, 32'd3);
        chk("col_n1_din",    rd_din, 32'h33);
        chk("col_n1_we",     {31'b0, reg_write}, 32'd1);
        chk("col_buf_valid", {31'b0, buf_valid}, 32'd1);
        chk("col_buf_rd",    {27'b0, buf_rd}, 32'd7);
        chk("col_ml_ready",  {31'b0, ml_ready}, 32'd0);
        tick();
        chk("col_n2_rd",  {27'b0, rd}, 32'd7);
        chk("col_n2_din", rd_din, 32'hAA);
        chk("col_n2_we",  {31'b0, reg_write}, 32'd1);
        chk("col_n2_buf", {31'b0, buf_valid}, 32'd0);

        // Direct ML bypass
        ml_valid = 1'b1; ml_rd = 5'd20; ml_data = 32'h55;
        chk("byp_ml_ready", {31'b0, ml_ready}, 32'd1);
        tick();
        ml_valid = 1'b0;
        chk("byp_rd",  {27'b0, rd}, 32'd20);
        chk("byp_din", rd_din, 32'h55);
        chk("byp_buf", {31'b0, buf_valid}, 32'd0);

        // Starvation
        wb_valid = 1'b1; wb_rd = 5'd10; wb_alu = 32'h100;
        ml_valid = 1'b1; ml_rd = 5'd11; ml_data = 32'hBB;
        tick();
        ml_valid = 1'b0;
        chk("stv_first_rd", {27'b0, rd}, 32'd10);
        for (int i = 0; i < 4; i++) begin
            wb_rd = 5'(13 + i); wb_alu = 32'h110 + i;
            chk($sformatf("stv%0d_wb_ready", i), {31'b0, wb_ready}, 32'd1);
            tick();
            chk($sformatf("stv%0d_rd", i),  {27'b0, rd}, 32'(13 + i));
            chk($sformatf("stv%0d_din", i), rd_din, 32'h110 + i);
        end
        wb_rd = 5'd17; wb_alu = 32'h117;
        chk("stv_stall_ready", {31'b0, wb_ready}, 32'd0);
        chk("stv_stall_buf",   {31'b0, buf_valid}, 32'd1);
        tick();
        chk("stv_buf_rd",    {27'b0, rd}, 32'd11);
        chk("stv_buf_din",   rd_din, 32'hBB);
        chk("stv_buf_we",    {31'b0, reg_write}, 32'd1);
        chk("stv_ready_back", {31'b0, wb_ready}, 32'd1);
        chk("stv_buf_empty", {31'b0, buf_valid}, 32'd0);
        tick();
        wb_valid = 1'b0;
        chk("stv_held_rd",  {27'b0, rd}, 32'd17);
        chk("stv_held_din", rd_din, 32'h117);

        // x0 suppression
        wb_valid = 1'b1; wb_rd = 5'd0; wb_alu = 32'hDEAD;
        chk("x0_wb_ready", {31'b0, wb_ready}, 32'd1);
        tick();
        wb_valid = 1'b0;
        chk("x0_we",  {31'b0, reg_write}, 32'd0);
        chk("x0_rd",  {27'b0, rd}, 32'd0);
        chk("x0_din", rd_din, 32'hDEAD);
        chk("x0_ready_after", {31'b0, wb_ready}, 32'd1);

        // Async reset with buffer full
        wb_valid = 1'b1; wb_rd = 5'd4; wb_alu = 32'h44;
        ml_valid = 1'b1; ml_rd = 5'd8; ml_data = 32'hCC;
        tick();
        wb_valid = 1'b0; ml_valid = 1'b0;
        chk("ar_pre_buf", {31'b0, buf_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_buf_valid", {31'b0, buf_valid}, 32'd0);
        chk("ar_we",        {31'b0, reg_write}, 32'd0);
        chk("ar_din",       rd_din, 32'd0);
        chk("ar_ml_ready",  {31'b0, ml_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_post_we1", {31'b0, reg_write}, 32'd0);
        tick();
        chk("ar_post_we2", {31'b0, reg_write}, 32'd0);
        chk("ar_post_din", rd_din, 32'd0);
        chk("ar_post_ml_ready", {31'b0, ml_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
